bram_read_arbiter: RTL and testbench
====================================

# bram_read_arbiter

Shares a single block-RAM read port between up to NUM_REQ streaming read requesters. Each cycle it grants one pending request, round-robin or fixed priority, and registers the winning address to the BRAM. It tracks the owner of every in-flight read through a tag pipeline matched to the BRAM latency, and returns each data word to the requester that issued it. It sits between the per-operand read modules and a shared BRAM, and replaces their direct request/address wiring.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- LOG_NUM_REQ, 2: bits for a requester index
- DATA_WIDTH, 8: BRAM data width
- LOG_MAX_ADDRESS, 16: BRAM address width
- BRAM_LATENCY, 1: cycles from bram_en to bram_data valid (1..4)

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- req_in  in  NUM_REQ  per-requester read request; held until granted
- addr_in  in  NUM_REQ*LOG_MAX_ADDRESS  flattened addresses; requester i at bits [i*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS]
- grant_out  out  NUM_REQ  one-hot grant (combinational); requester advances its address on grant
- bram_en  out  1  registered read enable to BRAM
- bram_addr  out  LOG_MAX_ADDRESS  registered read address to BRAM
- bram_data  in  DATA_WIDTH  BRAM read data, valid BRAM_LATENCY cycles after bram_en
- valid_out  out  NUM_REQ  one-hot registered data-valid, feeds each requester's valid_in
- data_out  out  DATA_WIDTH  registered return data, broadcast to all requesters

## Operation
- Grant: at most one bit of grant_out is set per cycle, and only for a requester with req_in set. grant_out is 0 when req_in is 0 and while rst is low.
- Round-robin: search starts at last_grant+1 and wraps modulo NUM_REQ. last_grant (LOG_NUM_REQ bits) updates only on a cycle with a grant.
- Issue: on a grant to requester i, the next edge sets bram_en=1, bram_addr=addr_in[i] and pushes tag {valid=1, id=i} into the tag pipeline. With no grant, bram_en=0, bram_addr holds its value and a bubble is pushed.
- Tag pipeline: BRAM_LATENCY stages of {valid, id}. The last stage is aligned with bram_data.
- Return: when the last stage is valid, the next edge sets valid_out=1<<id and data_out=bram_data. Otherwise valid_out=0 and data_out holds.
- No backpressure on the return path. Requesters size their FIFOs for the data in flight.
- Return order equals issue order. One request and one return per cycle sustained (full throughput).
- Requester contract:
  - req_in[i] and addr_in[i] stay stable until grant_out[i].
  - Dropping req_in without a grant is legal. The request is simply not served.
- Simultaneous grant and return in one cycle are independent, with no conflict.
- Reset mid-operation:
  - Clears all tags, so in-flight reads are discarded and never produce valid_out.
  - Sets last_grant to NUM_REQ-1, so requester 0 is first after release.

## Timing
- Reset values: bram_en=0, bram_addr=0, valid_out=0, data_out=0, last_grant=NUM_REQ-1, all tags invalid. grant_out=0 while rst is low.
- Cycle N: req_in[i] sampled and grant_out[i] asserted in the same cycle.
- N+1: bram_en/bram_addr presented.
- N+1+BRAM_LATENCY: bram_data sampled.
- N+2+BRAM_LATENCY: valid_out[i]/data_out presented for one cycle.
- Grant-to-data latency is BRAM_LATENCY+2 cycles.
- Address width passes through with no arithmetic. Index wrap is (last_grant+k) mod NUM_REQ with k in 1..NUM_REQ.

## Configuration
- BRAM_ARB_ROUND_ROBIN_EN defined: round-robin grant as above, starvation-free. Worst-case wait is NUM_REQ-1 cycles.
- Undefined:
  - Fixed priority; the lowest-index requesting input wins every cycle.
  - last_grant register is not implemented.
  - Everything else is identical.

## Test plan
- Single request (NUM_REQ=4, BRAM_LATENCY=1): req_in=0100, addr 2=0x0010 at cycle 0. Required:
  - cycle 0: grant_out=0100
  - cycle 1: bram_en=1, bram_addr=0x0010
  - cycle 2: BRAM drives bram_data=0xA5
  - cycle 3: valid_out=0100, data_out=0xA5
- Saturation: req_in=1111 held 8 cycles from reset. Required:
  - with BRAM_ARB_ROUND_ROBIN_EN: grants 0,1,2,3,0,1,2,3
  - without it: grant 0 every cycle
- Wrap: last grant to requester 3, then req_in=0011 → grant 0 then 1. With last grant 1 and req_in=1010 → grant 3 then 1.
- Tag ordering (BRAM_LATENCY=3): requesters 0,1,2 granted on consecutive cycles, BRAM returns 0x11,0x22,0x33. Required: valid_out=0001/0010/0100 on cycles 5,6,7 with the matching data.
- Reset mid-flight: rst dropped asynchronously with 2 reads in flight. Required:
  - all outputs 0 before the next edge
  - no valid_out after release
  - with req_in=1111, first grant is 0
- Idle: req_in=0000 for 10 cycles. Required: bram_en=0, grant_out=0, valid_out=0 after pipeline drain, bram_addr unchanged.

Source files
------------

// File: rtl/bram_read_arbiter_if.sv
// bram_read_arbiter_if: requester-side and BRAM-side signals of the shared read port.
// slave is the arbiter's view; master is the requesters/BRAM view.
interface bram_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LOG_MAX_ADDRESS = 16
);
  logic [NUM_REQ-1:0] req_in;
  logic [NUM_REQ*LOG_MAX_ADDRESS-1:0] addr_in;
  logic [NUM_REQ-1:0] grant_out;
  logic bram_en;
  logic [LOG_MAX_ADDRESS-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_data;
  logic [NUM_REQ-1:0] valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  modport master (
    output req_in, addr_in, bram_data,
    input grant_out, bram_en, bram_addr, valid_out, data_out
  );
  modport slave (
    input req_in, addr_in, bram_data,
    output grant_out, bram_en, bram_addr, valid_out, data_out
  );
endinterface

// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: shares one BRAM read port among NUM_REQ requesters and routes each return to its issuer.
// Define BRAM_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise lowest-index fixed priority.
module bram_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LOG_NUM_REQ = 2,
  parameter int DATA_WIDTH = 8,
  parameter int LOG_MAX_ADDRESS = 16,
  parameter int BRAM_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  bram_read_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic any_grant;
  logic [LOG_NUM_REQ-1:0] win;
  logic [LOG_MAX_ADDRESS-1:0] bram_addr_q, bram_addr_d;
  logic [BRAM_LATENCY:0] tag_v_q, tag_v_d;
  logic [LOG_NUM_REQ-1:0] tag_id_q [BRAM_LATENCY+1];
  logic [LOG_NUM_REQ-1:0] tag_id_d [BRAM_LATENCY+1];
  logic [NUM_REQ-1:0] valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  assign req = rst ? bus.req_in : '0;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
  logic [LOG_NUM_REQ-1:0] last_grant_q, last_grant_d;
  logic [LOG_NUM_REQ-1:0] cand;
  always_comb begin
    any_grant = 1'b0;
    win = '0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = LOG_NUM_REQ'((int'(last_grant_q) + k) % NUM_REQ);
      if (!any_grant && req[cand]) begin
        any_grant = 1'b1;
        win = cand;
      end
    end
    last_grant_d = any_grant ? win : last_grant_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_grant_q <= LOG_NUM_REQ'(NUM_REQ - 1);
    else last_grant_q <= last_grant_d;
`else
  always_comb begin
    any_grant = 1'b0;
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[k]) begin
        any_grant = 1'b1;
        win = LOG_NUM_REQ'(k);
      end
  end
`endif
  assign grant = any_grant ? NUM_REQ'(1) << win : '0;
  // Stage 0 of the tag pipe coincides with bram_en; the last stage lines up with bram_data.
  always_comb begin
    tag_v_d = {tag_v_q[BRAM_LATENCY-1:0], any_grant};
    tag_id_d[0] = win;
    for (int s = 1; s <= BRAM_LATENCY; s++) tag_id_d[s] = tag_id_q[s-1];
    bram_addr_d = any_grant ? bus.addr_in[win*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS] : bram_addr_q;
    valid_out_d = tag_v_q[BRAM_LATENCY] ? NUM_REQ'(1) << tag_id_q[BRAM_LATENCY] : '0;
    data_out_d = tag_v_q[BRAM_LATENCY] ? bus.bram_data : data_out_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tag_v_q <= '0;
      tag_id_q <= '{default: '0};
      bram_addr_q <= '0;
      valid_out_q <= '0;
      data_out_q <= '0;
    end else begin
      tag_v_q <= tag_v_d;
      tag_id_q <= tag_id_d;
      bram_addr_q <= bram_addr_d;
      valid_out_q <= valid_out_d;
      data_out_q <= data_out_d;
    end
  assign bus.grant_out = grant;
  assign bus.bram_en = tag_v_q[0];
  assign bus.bram_addr = bram_addr_q;
  assign bus.valid_out = valid_out_q;
  assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb_bram_read_arbiter: random requesters and a latency-accurate BRAM model, checked against a
// cycle-scheduled reference of grants, issues and returns.
module tb_bram_read_arbiter;
  localparam int N = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bram_read_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .LOG_MAX_ADDRESS(AW)) bus ();
  bram_read_arbiter #(
    .NUM_REQ(N), .LOG_NUM_REQ(2), .DATA_WIDTH(DW), .LOG_MAX_ADDRESS(AW), .BRAM_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic [N-1:0] pend = '0;
  logic [AW-1:0] addr_r [N];
  int last = N - 1;
  int cyc = 0;
  logic exp_en = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_do = '0;
  int sv [16];
  logic [DW-1:0] sd [16];
  logic bp_v [LAT];
  logic [AW-1:0] bp_a [LAT];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB5;
  endfunction
  function automatic int pick(input logic [N-1:0] r);
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction
  task automatic clear_model();
    exp_en = 1'b0;
    exp_addr = '0;
    exp_do = '0;
    last = N - 1;
    for (int i = 0; i < 16; i++) sv[i] = -1;
  endtask
  task automatic tick();
    logic [N-1:0] g;
    int id;
    int ev;
    logic en_s;
    logic [AW-1:0] addr_s;
    bus.req_in = pend;
    for (int i = 0; i < N; i++) bus.addr_in[i*AW +: AW] = addr_r[i];
    @(negedge clk);
    g = '0;
    id = rst ? pick(pend) : -1;
    if (id >= 0) g[id] = 1'b1;
    check("grant_out", 32'(bus.grant_out), 32'(g));
    check("bram_en", 32'(bus.bram_en), 32'(exp_en));
    check("bram_addr", 32'(bus.bram_addr), 32'(exp_addr));
    ev = sv[cyc % 16];
    if (ev >= 0) exp_do = sd[cyc % 16];
    sv[cyc % 16] = -1;
    check("valid_out", 32'(bus.valid_out), ev >= 0 ? 32'd1 << ev : 32'd0);
    check("data_out", 32'(bus.data_out), 32'(exp_do));
    en_s = bus.bram_en;
    addr_s = bus.bram_addr;
    @(posedge clk);
    for (int i = LAT - 1; i > 0; i--) begin
      bp_v[i] = bp_v[i-1];
      bp_a[i] = bp_a[i-1];
    end
    bp_v[0] = en_s;
    bp_a[0] = addr_s;
    if (rst) begin
      exp_en = id >= 0;
      if (id >= 0) begin
        exp_addr = addr_r[id];
        sv[(cyc + 2 + LAT) % 16] = id;
        sd[(cyc + 2 + LAT) % 16] = mem(addr_r[id]);
        last = id;
        pend[id] = 1'b0;
        addr_r[id] = AW'($urandom);
      end
    end
    cyc++;
    #1;
    bus.bram_data = bp_v[LAT-1] ? mem(bp_a[LAT-1]) : DW'($urandom);
  endtask
  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    clear_model();
    check("rst_grant", 32'(bus.grant_out), 32'd0);
    check("rst_bram_en", 32'(bus.bram_en), 32'd0);
    check("rst_bram_addr", 32'(bus.bram_addr), 32'd0);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    tick();
    tick();
    rst = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < N; i++) addr_r[i] = AW'($urandom);
    for (int i = 0; i < LAT; i++) begin
      bp_v[i] = 1'b0;
      bp_a[i] = '0;
    end
    bus.req_in = '0;
    bus.addr_in = '0;
    bus.bram_data = '0;
    clear_model();
    // Power-up reset with a request already pending to confirm grant gating.
    pend = 4'b1111;
    #1;
    rst = 1'b0;
    #2;
    check("init_grant", 32'(bus.grant_out), 32'd0);
    check("init_bram_en", 32'(bus.bram_en), 32'd0);
    check("init_bram_addr", 32'(bus.bram_addr), 32'd0);
    check("init_valid", 32'(bus.valid_out), 32'd0);
    check("init_data", 32'(bus.data_out), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    pend = '0;
    tick();
    pend = 4'b0100;
    addr_r[2] = 16'h0010;
    repeat (8) tick();
    repeat (10) tick();
    mid_reset();
    repeat (8) begin
      pend = 4'b1111;
      tick();
    end
    pend = 4'b0011;
    tick();
    tick();
    pend = 4'b1010;
    tick();
    tick();
    repeat (8) tick();
    mid_reset();
    pend = 4'b0111;
    repeat (3) tick();
    repeat (8) tick();
    pend = 4'b0011;
    tick();
    tick();
    pend = 4'b1111;
    mid_reset();
    repeat (8) tick();
    repeat (500) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) pend[i] = 1'b1;
        else if (pend[i] && $urandom_range(15, 0) == 0) begin
          pend[i] = 1'b0;
          addr_r[i] = AW'($urandom);
        end
      end
      if ($urandom_range(99, 0) == 0) mid_reset();
      tick();
    end
    pend = '0;
    repeat (10) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
